x_mem_loader: RTL and testbench

- Writer-side counterpart of the read-only X memory consumed by the network datapath.
- Accepts X words over a valid/ready stream and stores them in a DEPTH-entry register file, using an internal write-address counter.
- Presents a combinational read port (read_en, addr, val_out) that drops in where the datapath's address counter and memory read currently connect.
- Asserts loaded once all DEPTH words are present, which gates the controller's start of iteration.

---
 rtl/x_mem_loader.sv | 94 +++++++++
 tb/tb_x_mem_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/x_mem_loader.sv
// x_mem_loader: stream-fed X register file with a combinational read port.
// Counts accepted words and raises loaded once every entry has been written.
module x_mem_loader #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              read_en,
   input  logic [ADDR_W-1:0] addr,
   output logic [WIDTH-1:0]  val_out,
   output logic              loaded,
   output logic [ADDR_W:0]   count,
   output logic              ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             accept;

   // Words are only taken while loading and never in a restart cycle.
   always_comb begin
      in_ready = (state == LOAD) && !start;
      accept   = in_ready && in_valid;
   end

   // Load state machine, write counter, status flags and storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         loaded <= 1'b0;
         ovf    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  count <= '0;
                  ovf   <= 1'b0;
               end
            end
            LOAD: begin
               if (start) begin
                  count <= '0;
               end else if (accept) begin
                  mem[count[ADDR_W-1:0]] <= in_data;
                  count <= count + ONE;
                  if (count == LAST) begin
                     state  <= FULL;
                     loaded <= 1'b1;
                  end
               end
            end
            FULL: begin
               if (start) begin
                  state  <= LOAD;
                  count  <= '0;
                  loaded <= 1'b0;
                  ovf    <= 1'b0;
               end else if (in_valid) begin
                  ovf <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Combinational read; a same-cycle write is seen only from the next cycle.
   always_comb begin
      val_out = read_en ? mem[addr] : '0;
   end

endmodule

// File: tb/tb_x_mem_loader.sv
// tb_x_mem_loader: randomized and directed stimulus against a queue-based
// reference model; a negedge monitor pops expectations and compares.
module tb_x_mem_loader;

   localparam int W = 32;
   localparam int D = 4;
   localparam int A = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         read_en = 1'b0;
   logic [A-1:0] addr = '0;
   logic [W-1:0] val_out;
   logic         loaded;
   logic [A:0]   count;
   logic         ovf;

   typedef struct packed {
      logic         rdy;
      logic [A:0]   cnt;
      logic         ld;
      logic         ov;
      logic [W-1:0] val;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;

   // Reference model state: load session active, words taken, data, overflow.
   bit           m_active;
   int           m_n;
   bit           m_ovf;
   logic [W-1:0] m_mem [D];

   x_mem_loader #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .read_en(read_en), .addr(addr), .val_out(val_out),
      .loaded(loaded), .count(count), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req,
                  $time);
      end
   endtask

   // Monitor: compare DUT outputs with the oldest pending expectation.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("in_ready", {31'd0, in_ready}, {31'd0, e.rdy});
         chk("count", {29'd0, count}, {29'd0, e.cnt});
         chk("loaded", {31'd0, loaded}, {31'd0, e.ld});
         chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
         chk("val_out", val_out, e.val);
      end
   end

   task automatic model_reset();
      m_active = 1'b0;
      m_n = 0;
      m_ovf = 1'b0;
      for (int i = 0; i < D; i++) m_mem[i] = '0;
   endtask

   // Drive one cycle, queue what the outputs must be, then advance the model.
   task automatic step(input bit r, input bit s, input bit v,
                       input logic [W-1:0] d, input bit re,
                       input logic [A-1:0] a);
      exp_t e;
      bit   rdy;
      rst = r; start = s; in_valid = v; in_data = d;
      read_en = re; addr = a;
      rdy   = m_active && (m_n < D) && !s;
      e.rdy = rdy;
      e.cnt = (A+1)'(m_n);
      e.ld  = m_active && (m_n == D);
      e.ov  = m_ovf;
      e.val = re ? m_mem[a] : '0;
      q.push_back(e);
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (s) begin
         m_active = 1'b1;
         m_n = 0;
         m_ovf = 1'b0;
      end else if (rdy && v) begin
         m_mem[m_n] = d;
         m_n++;
      end else if (m_active && m_n == D && v) begin
         m_ovf = 1'b1;
      end
      #1;
   endtask

   task automatic idle_reads();
      for (int i = 0; i < D; i++) step(0, 0, 0, '0, 1, A'(i));
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      // Reset then idle: in_valid ignored, memory reads zero.
      for (int i = 0; i < D; i++) step(0, 0, 1, 32'h55, 1, A'(i));
      // Full load on consecutive edges, then readback.
      step(0, 1, 0, '0, 1, 0);
      step(0, 0, 1, 32'h11, 1, 0);
      step(0, 0, 1, 32'h22, 1, 0);
      step(0, 0, 1, 32'h33, 1, 1);
      step(0, 0, 1, 32'h44, 1, 3);
      idle_reads();
      step(0, 0, 0, '0, 0, 2);
      // Overflow while full, then start clears it.
      step(0, 0, 1, 32'hDEAD, 1, 0);
      step(0, 0, 0, '0, 1, 0);
      idle_reads();
      step(0, 1, 0, '0, 1, 3);
      // Gapped producer.
      for (int i = 0; i < 8; i++)
         step(0, 0, (i % 2) == 0, 32'hF0 + i, 1, A'(i / 2));
      idle_reads();
      // Restart mid-load with a concurrent word that must be dropped.
      step(0, 1, 0, '0, 0, 0);
      step(0, 0, 1, 32'hA, 1, 0);
      step(0, 0, 1, 32'hB, 1, 1);
      step(0, 1, 1, 32'hC, 1, 2);
      for (int i = 1; i <= 4; i++) step(0, 0, 1, W'(i), 1, 2);
      idle_reads();
      // Reset mid-load.
      step(0, 1, 0, '0, 0, 0);
      step(0, 0, 1, 32'h77, 0, 0);
      step(0, 0, 1, 32'h88, 0, 0);
      step(1, 0, 1, 32'h99, 1, 0);
      idle_reads();
      step(0, 1, 0, '0, 1, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h100 + i, 1, A'(i));
      idle_reads();
      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 11) == 0),
              $urandom_range(0, 1) == 1,
              $urandom,
              $urandom_range(0, 3) != 0,
              A'($urandom_range(0, D - 1)));
      end
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
